// File: rtl/timer_digit_entry.sv
// Keypad digit entry: debounces presses from the keypad coder and shifts BCD digits into MM:SS.
// Optional macro SECONDS_CHECK_EN builds a registered seconds-tens range flag on time_valid.
module timer_digit_entry #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] data,
   input  logic       valid_input,
   input  logic       enable,
   input  logic       clear,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic [2:0] digit_count,
   output logic       new_digit,
   output logic       reject,
   output logic       entry_busy,
   output logic       time_valid
);

   typedef enum logic [1:0] {StIdle, StDebounce, StWaitRelease} state_e;

   localparam logic [15:0] DbLimit = 16'(DEBOUNCE_CYCLES);

   state_e      state_q, state_d;
   logic [15:0] count_q, count_d;
   logic [3:0]  captured_q, captured_d;
   logic [3:0]  min_tens_q, min_tens_d;
   logic [3:0]  min_ones_q, min_ones_d;
   logic [3:0]  sec_tens_q, sec_tens_d;
   logic [3:0]  sec_ones_q, sec_ones_d;
   logic [2:0]  digits_q, digits_d;
   logic        new_digit_q, new_digit_d;
   logic        reject_q, reject_d;
   logic        commit;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         count_q     <= '0;
         captured_q  <= '0;
         min_tens_q  <= '0;
         min_ones_q  <= '0;
         sec_tens_q  <= '0;
         sec_ones_q  <= '0;
         digits_q    <= '0;
         new_digit_q <= 1'b0;
         reject_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         captured_q  <= captured_d;
         min_tens_q  <= min_tens_d;
         min_ones_q  <= min_ones_d;
         sec_tens_q  <= sec_tens_d;
         sec_ones_q  <= sec_ones_d;
         digits_q    <= digits_d;
         new_digit_q <= new_digit_d;
         reject_q    <= reject_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      captured_d  = captured_q;
      min_tens_d  = min_tens_q;
      min_ones_d  = min_ones_q;
      sec_tens_d  = sec_tens_q;
      sec_ones_d  = sec_ones_q;
      digits_d    = digits_q;
      new_digit_d = 1'b0;
      reject_d    = 1'b0;
      commit      = 1'b0;

      if (clear) begin
         state_d    = StIdle;
         count_d    = '0;
         min_tens_d = '0;
         min_ones_d = '0;
         sec_tens_d = '0;
         sec_ones_d = '0;
         digits_d   = '0;
      end else if (state_q == StDebounce && !enable) begin
         state_d = StIdle;
         count_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (valid_input && enable) begin
                  captured_d = data;
                  count_d    = 16'd1;
                  state_d    = StDebounce;
               end
            end
            StDebounce: begin
               // Non-BCD codes fail the stability check so they can never be committed.
               if (!valid_input || data != captured_q || captured_q > 4'd9) begin
                  state_d = StIdle;
                  count_d = '0;
               end else if (count_q == DbLimit) begin
                  commit  = 1'b1;
                  count_d = '0;
                  state_d = StWaitRelease;
               end else begin
                  count_d = count_q + 16'd1;
               end
            end
            StWaitRelease: begin
               if (valid_input) begin
                  count_d = '0;
               end else if (count_q + 16'd1 == DbLimit) begin
                  count_d = '0;
                  state_d = StIdle;
               end else begin
                  count_d = count_q + 16'd1;
               end
            end
            default: begin
               state_d = StIdle;
               count_d = '0;
            end
         endcase
      end

      if (commit) begin
         if (digits_q < 3'd4) begin
            min_tens_d  = min_ones_q;
            min_ones_d  = sec_tens_q;
            sec_tens_d  = sec_ones_q;
            sec_ones_d  = captured_q;
            digits_d    = digits_q + 3'd1;
            new_digit_d = 1'b1;
         end else begin
            reject_d = 1'b1;
         end
      end
   end

   assign min_tens    = min_tens_q;
   assign min_ones    = min_ones_q;
   assign sec_tens    = sec_tens_q;
   assign sec_ones    = sec_ones_q;
   assign digit_count = digits_q;
   assign new_digit   = new_digit_q;
   assign reject      = reject_q;
   assign entry_busy  = (state_q != StIdle);

`ifdef SECONDS_CHECK_EN
   logic time_valid_q;

   // Tracks the next seconds value so the flag lines up with the registered digits.
   always_ff @(posedge clk) begin
      if (reset) begin
         time_valid_q <= 1'b1;
      end else begin
         time_valid_q <= (sec_tens_d <= 4'd5);
      end
   end

   assign time_valid = time_valid_q;
`else
   assign time_valid = 1'b1;
`endif

endmodule

// File: tb/tb_timer_digit_entry.sv
// Self-checking bench for timer_digit_entry: directed scenarios plus randomized key events
// compared cycle by cycle against a behavioural model that keeps the time as an integer.
module tb_timer_digit_entry;

   localparam int unsigned D = 4;

   logic       clk = 1'b0;
   logic       reset, valid_input, enable, clear;
   logic [3:0] data;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic [2:0] digit_count;
   logic       new_digit, reject, entry_busy, time_valid;
   logic [22:0] dut_out;

   int checks = 0;
   int errors = 0;
   int seen_new = 0;
   int seen_rej = 0;

   // Reference model: time as decimal integer MMSS, phase 0 idle, 1 pressing, 2 releasing.
   int m_time, m_count, m_phase, m_cnt, m_cap;
   bit m_new, m_rej;

   timer_digit_entry #(.DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .reset(reset), .data(data), .valid_input(valid_input), .enable(enable),
      .clear(clear), .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
      .sec_ones(sec_ones), .digit_count(digit_count), .new_digit(new_digit), .reject(reject),
      .entry_busy(entry_busy), .time_valid(time_valid)
   );

   always #5 clk = ~clk;

   assign dut_out = {min_tens, min_ones, sec_tens, sec_ones, digit_count, new_digit, reject,
                     entry_busy, time_valid};

   function automatic logic [22:0] model_outputs();
      logic tv;
`ifdef SECONDS_CHECK_EN
      tv = (((m_time / 10) % 10) <= 5);
`else
      tv = 1'b1;
`endif
      return {4'(m_time / 1000), 4'((m_time / 100) % 10), 4'((m_time / 10) % 10),
              4'(m_time % 10), 3'(m_count), m_new, m_rej, (m_phase != 0), tv};
   endfunction

   task automatic model_edge(input int d, input bit v, input bit en, input bit clr, input bit rst);
      m_new = 0;
      m_rej = 0;
      if (rst) begin
         m_time = 0; m_count = 0; m_phase = 0; m_cnt = 0; m_cap = 0;
      end else if (clr) begin
         m_time = 0; m_count = 0; m_phase = 0; m_cnt = 0;
      end else if (m_phase == 1 && !en) begin
         m_phase = 0; m_cnt = 0;
      end else if (m_phase == 0) begin
         if (v && en) begin m_cap = d; m_cnt = 1; m_phase = 1; end
      end else if (m_phase == 1) begin
         if (!v || d != m_cap || m_cap > 9) begin
            m_phase = 0; m_cnt = 0;
         end else if (m_cnt == D) begin
            if (m_count < 4) begin
               m_time = (m_time * 10 + m_cap) % 10000;
               m_count++;
               m_new = 1;
            end else begin
               m_rej = 1;
            end
            m_cnt = 0; m_phase = 2;
         end else begin
            m_cnt++;
         end
      end else begin
         if (v) m_cnt = 0;
         else if (m_cnt + 1 == D) begin m_cnt = 0; m_phase = 0; end
         else m_cnt++;
      end
   endtask

   // Drives one cycle at the falling edge, advances the model on the rising edge.
   task automatic step(input logic [3:0] d, input bit v, input bit en, input bit clr, input bit rst);
      data = d; valid_input = v; enable = en; clear = clr; reset = rst;
      @(posedge clk);
      model_edge(int'(d), v, en, clr, rst);
      @(negedge clk);
      if (new_digit === 1'b1) seen_new++;
      if (reject === 1'b1) seen_rej++;
   endtask

   task automatic press(input logic [3:0] d, input int hold, input int rel);
      for (int i = 0; i < hold; i++) step(d, 1, 1, 0, 0);
      for (int i = 0; i < rel; i++) step(4'd0, 0, 1, 0, 0);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom), 1);
         checks++;
         if (dut_out !== {16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", dut_out, {19'h0, 4'b0001});
         end
      end
      step(4'd0, 0, 1, 0, 0);
   endtask

   task automatic test_single_press();
      int first = -1;
      seen_new = 0;
      for (int i = 0; i < 10; i++) begin
         step(4'd5, 1, 1, 0, 0);
         if (new_digit === 1'b1 && first < 0) first = i;
         if (i == 3) begin
            checks++;
            if (sec_ones !== 4'd0) begin
               errors++;
               $display("FAIL single_early: sec_ones got %0d expected 0", sec_ones);
            end
         end
      end
      for (int i = 0; i < D + 2; i++) step(4'd0, 0, 1, 0, 0);
      checks++;
      if (first != 4) begin
         errors++;
         $display("FAIL single_latency: pulse at %0d expected 4", first);
      end
      checks++;
      if (seen_new != 1 || sec_ones !== 4'd5 || digit_count !== 3'd1) begin
         errors++;
         $display("FAIL single_result: pulses %0d sec_ones %0d count %0d expected 1 5 1",
                  seen_new, sec_ones, digit_count);
      end
      checks++;
      if (dut_out !== model_outputs()) begin
         errors++;
         $display("FAIL single_model: got %h expected %h", dut_out, model_outputs());
      end
   endtask

   task automatic test_sequence();
      step(4'd0, 0, 1, 1, 0);
      seen_new = 0; seen_rej = 0;
      press(4'd1, 6, 5); press(4'd2, 6, 5); press(4'd3, 6, 5); press(4'd0, 6, 5);
      checks++;
      if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h1230 || digit_count !== 3'd4
          || seen_new != 4 || seen_rej != 0) begin
         errors++;
         $display("FAIL seq_1230: got %h count %0d pulses %0d/%0d expected 1230 4 4/0",
                  {min_tens, min_ones, sec_tens, sec_ones}, digit_count, seen_new, seen_rej);
      end
      press(4'd7, 6, 5);
      checks++;
      if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h1230 || digit_count !== 3'd4
          || seen_new != 4 || seen_rej != 1) begin
         errors++;
         $display("FAIL seq_reject: got %h count %0d pulses %0d/%0d expected 1230 4 4/1",
                  {min_tens, min_ones, sec_tens, sec_ones}, digit_count, seen_new, seen_rej);
      end
   endtask

   task automatic test_glitch();
      step(4'd0, 0, 1, 1, 0);
      seen_new = 0; seen_rej = 0;
      press(4'd6, 2, 2);
      step(4'd3, 1, 1, 0, 0); step(4'd3, 1, 1, 0, 0);
      step(4'd8, 1, 1, 0, 0);
      checks++;
      if (entry_busy !== 1'b0) begin
         errors++;
         $display("FAIL glitch_abort: entry_busy got %b expected 0", entry_busy);
      end
      press(4'd8, 3, 6);
      checks++;
      if (seen_new != 0 || seen_rej != 0 || digit_count !== 3'd0 || entry_busy !== 1'b0) begin
         errors++;
         $display("FAIL glitch_none: pulses %0d/%0d count %0d busy %b expected 0/0 0 0",
                  seen_new, seen_rej, digit_count, entry_busy);
      end
   endtask

   task automatic test_held_bounce();
      step(4'd0, 0, 1, 1, 0);
      seen_new = 0;
      for (int i = 0; i < 100; i++) step(4'd4, 1, 1, 0, 0);
      step(4'd0, 0, 1, 0, 0); step(4'd0, 0, 1, 0, 0);
      step(4'd4, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(4'd0, 0, 1, 0, 0);
      checks++;
      if (entry_busy !== 1'b1 || seen_new != 1) begin
         errors++;
         $display("FAIL held_one: busy %b pulses %0d expected 1 1", entry_busy, seen_new);
      end
      step(4'd0, 0, 1, 0, 0);
      checks++;
      if (entry_busy !== 1'b0) begin
         errors++;
         $display("FAIL held_release: busy %b expected 0", entry_busy);
      end
      press(4'd6, 6, 5);
      checks++;
      if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0046 || digit_count !== 3'd2) begin
         errors++;
         $display("FAIL held_next: got %h count %0d expected 0046 2",
                  {min_tens, min_ones, sec_tens, sec_ones}, digit_count);
      end
   endtask

   task automatic test_clear_reset();
      step(4'd0, 0, 1, 1, 0);
      press(4'd2, 6, 5);
      for (int i = 0; i < D; i++) step(4'd9, 1, 1, 0, 0);
      step(4'd9, 1, 1, 1, 0);
      checks++;
      if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0 || digit_count !== 3'd0
          || new_digit !== 1'b0 || reject !== 1'b0) begin
         errors++;
         $display("FAIL clear_commit: got %h count %0d new %b rej %b expected 0 0 0 0",
                  {min_tens, min_ones, sec_tens, sec_ones}, digit_count, new_digit, reject);
      end
      for (int i = 0; i < D + 2; i++) step(4'd0, 0, 1, 0, 0);
      press(4'd3, 6, 5);
      seen_new = 0;
      step(4'd5, 1, 1, 0, 0); step(4'd5, 1, 1, 0, 0);
      step(4'd5, 1, 1, 0, 1);
      for (int i = 0; i < D + 2; i++) step(4'd0, 0, 1, 0, 0);
      checks++;
      if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0 || digit_count !== 3'd0
          || seen_new != 0 || entry_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_debounce: got %h count %0d pulses %0d busy %b expected 0 0 0 0",
                  {min_tens, min_ones, sec_tens, sec_ones}, digit_count, seen_new, entry_busy);
      end
   endtask

   task automatic test_seconds();
      logic exp_tv;
`ifdef SECONDS_CHECK_EN
      exp_tv = 1'b0;
`else
      exp_tv = 1'b1;
`endif
      step(4'd0, 0, 1, 1, 0);
      press(4'd0, 6, 5); press(4'd0, 6, 5); press(4'd9, 6, 5);
      checks++;
      if (sec_tens !== 4'd0 || time_valid !== 1'b1) begin
         errors++;
         $display("FAIL seconds_third: sec_tens %0d tv %b expected 0 1", sec_tens, time_valid);
      end
      press(4'd0, 6, 5);
      checks++;
      if (sec_tens !== 4'd9 || time_valid !== exp_tv) begin
         errors++;
         $display("FAIL seconds_fourth: sec_tens %0d tv %b expected 9 %b",
                  sec_tens, time_valid, exp_tv);
      end
   endtask

   task automatic test_random();
      for (int e = 0; e < 150; e++) begin
         logic [3:0] d;
         int hold, rel;
         bit en;
         d = 4'($urandom_range(0, 11));
         hold = $urandom_range(1, 9);
         rel = $urandom_range(0, 7);
         en = ($urandom_range(0, 7) != 0);
         for (int i = 0; i < hold + rel; i++) begin
            bit v, clr, rst, en_c;
            v = (i < hold) ? ($urandom_range(0, 11) != 0) : 1'b0;
            clr = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 199) == 0);
            en_c = en ^ ($urandom_range(0, 19) == 0);
            step((i < hold) ? d : 4'($urandom_range(0, 15)), v, en_c, clr, rst);
            checks++;
            if (dut_out !== model_outputs()) begin
               errors++;
               $display("FAIL random_e%0d_c%0d: got %h expected %h", e, i, dut_out,
                        model_outputs());
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1; data = 4'd0; valid_input = 1'b0; enable = 1'b1; clear = 1'b0;
      m_time = 0; m_count = 0; m_phase = 0; m_cnt = 0; m_cap = 0; m_new = 0; m_rej = 0;
      @(negedge clk);
      test_reset();
      test_single_press();
      test_sequence();
      test_glitch();
      test_held_bounce();
      test_clear_reset();
      test_seconds();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
